// File: rtl/iter_muldiv_unit_if.sv
// Handshake and operand bundle between the EX stage and the iterative mul/div unit.
// The master drives the request side; the slave is the unit itself.
interface iter_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic [2:0]           op_i;
    logic [WIDTH-1:0]     src1_i;
    logic [WIDTH-1:0]     src2_i;
    logic [WIDTH-1:0]     hi_i;
    logic [WIDTH-1:0]     lo_i;
    logic                 annul_i;
    logic                 busy_o;
    logic                 ready_o;
    logic [2*WIDTH-1:0]   result_o;
    logic                 div_by_zero_o;

    modport master (
        output start_i, op_i, src1_i, src2_i, hi_i, lo_i, annul_i,
        input  busy_o, ready_o, result_o, div_by_zero_o
    );

    modport slave (
        input  start_i, op_i, src1_i, src2_i, hi_i, lo_i, annul_i,
        output busy_o, ready_o, result_o, div_by_zero_o
    );
endinterface

// File: rtl/iter_muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply (MUL_BPC bits per cycle),
// radix-2 restoring divide, HI/LO accumulate, start/ready/annul handshake.
module iter_muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_BPC = 1
) (
    input  logic              clk,
    input  logic              resetn,
    iter_muldiv_unit_if.slave bus
);
    localparam int MUL_ITERS = WIDTH / MUL_BPC;
    localparam int CNT_W     = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           accMode_q, accMode_d;
    logic                 negA_q, negA_d;
    logic                 negB_q, negB_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [2*WIDTH-1:0]   hiLo_q, hiLo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 dbz_q, dbz_d;

    logic                 srcSigned;
    logic                 isDivOp;
    logic                 accept;
    logic [WIDTH-1:0]     magA;
    logic [WIDTH-1:0]     magB;
    logic [2*WIDTH-1:0]   mulSum;
    logic [2*WIDTH-1:0]   prodFixed;
    logic [2*WIDTH-1:0]   mulResult;
    logic [WIDTH:0]       divShift;
    logic [WIDTH+1:0]     divDiff;
    logic                 divBorrow;
    logic [WIDTH-1:0]     remNext;
    logic [WIDTH-1:0]     quotNext;
    logic [WIDTH-1:0]     quotFixed;
    logic [WIDTH-1:0]     remFixed;

    // Datapath: operand magnitudes, one multiply step, one divide step, final sign fix-up.
    always_comb begin
        srcSigned = ~bus.op_i[0];
        isDivOp   = (bus.op_i[2:1] == 2'b01);
        accept    = bus.start_i && !bus.annul_i && (state_q == IDLE || state_q == DONE);
        magA      = (srcSigned && bus.src1_i[WIDTH-1]) ? -bus.src1_i : bus.src1_i;
        magB      = (srcSigned && bus.src2_i[WIDTH-1]) ? -bus.src2_i : bus.src2_i;

        mulSum = prod_q;
        for (int b = 0; b < MUL_BPC; b++) begin
            if (mplier_q[b]) begin
                mulSum = mulSum + (mcand_q << b);
            end
        end
        prodFixed = (negA_q ^ negB_q) ? -mulSum : mulSum;
        case (accMode_q)
            2'b10:   mulResult = hiLo_q + prodFixed;
            2'b11:   mulResult = hiLo_q - prodFixed;
            default: mulResult = prodFixed;
        endcase

        // The extra top bit of divDiff is the borrow that decides restore vs. keep.
        divShift  = {rem_q, mplier_q[WIDTH-1]};
        divDiff   = {1'b0, divShift} - {2'b00, mcand_q[WIDTH-1:0]};
        divBorrow = divDiff[WIDTH+1];
        remNext   = divBorrow ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
        quotNext  = {mplier_q[WIDTH-2:0], ~divBorrow};
        quotFixed = (negA_q ^ negB_q) ? -quotNext : quotNext;
        remFixed  = negA_q ? -remNext : remNext;
    end

    always_comb begin
        state_d   = state_q;
        accMode_d = accMode_q;
        negA_d    = negA_q;
        negB_d    = negB_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        rem_d     = rem_q;
        prod_d    = prod_q;
        hiLo_d    = hiLo_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    accMode_d = bus.op_i[2:1];
                    negA_d    = srcSigned & bus.src1_i[WIDTH-1];
                    negB_d    = srcSigned & bus.src2_i[WIDTH-1];
                    hiLo_d    = {bus.hi_i, bus.lo_i};
                    cnt_d     = '0;
                    prod_d    = '0;
                    rem_d     = '0;
                    if (isDivOp) begin
                        mcand_d  = {{WIDTH{1'b0}}, magB};
                        mplier_d = magA;
                        if (bus.src2_i == '0) begin
                            state_d  = DONE;
                            result_d = {bus.src1_i, {WIDTH{1'b1}}};
                            dbz_d    = 1'b1;
                        end else begin
                            state_d = DIV;
                        end
                    end else begin
                        mcand_d  = {{WIDTH{1'b0}}, magA};
                        mplier_d = magB;
                        state_d  = MUL;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (bus.annul_i) begin
                    state_d = IDLE;
                end else begin
                    prod_d   = mulSum;
                    mcand_d  = mcand_q << MUL_BPC;
                    mplier_d = mplier_q >> MUL_BPC;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(MUL_ITERS - 1)) begin
                        state_d  = DONE;
                        result_d = mulResult;
                        dbz_d    = 1'b0;
                    end
                end
            end
            DIV: begin
                if (bus.annul_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d    = remNext;
                    mplier_d = quotNext;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = DONE;
                        result_d = {remFixed, quotFixed};
                        dbz_d    = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            accMode_q <= '0;
            negA_q    <= 1'b0;
            negB_q    <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            prod_q    <= '0;
            hiLo_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            accMode_q <= accMode_d;
            negA_q    <= negA_d;
            negB_q    <= negB_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            rem_q     <= rem_d;
            prod_q    <= prod_d;
            hiLo_q    <= hiLo_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.busy_o        = (state_q == MUL) || (state_q == DIV);
    assign bus.ready_o       = (state_q == DONE);
    assign bus.result_o      = result_q;
    assign bus.div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Scoreboard bench for iter_muldiv_unit: expected results are queued at start
// and checked (value, flag, latency) whenever the unit raises ready_o.
module tb_iter_muldiv_unit;
    logic clk;
    logic resetn;
    int   total;
    int   bad;
    int   edgeCnt;
    logic [63:0] lastRes;

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        int          startEdge;
        int          cyc;
    } sb_item_t;

    sb_item_t sbQ[$];

    iter_muldiv_unit_if #(.WIDTH(32)) bus0 ();
    iter_muldiv_unit_if #(.WIDTH(32)) bus1 ();

    iter_muldiv_unit #(.WIDTH(32), .MUL_BPC(1)) dut0 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    iter_muldiv_unit #(.WIDTH(32), .MUL_BPC(4)) dut1 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] modelOp(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
        logic [63:0] sProd;
        logic [63:0] uProd;
        logic [63:0] hl;
        logic [63:0] res;
        logic        dbz;
        int          sa;
        int          sbv;
        sProd = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        uProd = {32'h0, a} * {32'h0, b};
        hl    = {hi, lo};
        dbz   = 1'b0;
        res   = 64'h0;
        case (op)
            3'd0: res = sProd;
            3'd1: res = uProd;
            3'd4: res = hl + sProd;
            3'd5: res = hl + uProd;
            3'd6: res = hl - sProd;
            3'd7: res = hl - uProd;
            3'd2: begin
                if (b == 32'h0) begin
                    dbz = 1'b1;
                    res = {a, 32'hFFFFFFFF};
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    res = {32'h0, a};
                end else begin
                    sa  = a;
                    sbv = b;
                    res = {32'(sa % sbv), 32'(sa / sbv)};
                end
            end
            default: begin
                if (b == 32'h0) begin
                    dbz = 1'b1;
                    res = {a, 32'hFFFFFFFF};
                end else begin
                    res = {a % b, a / b};
                end
            end
        endcase
        return {dbz, res};
    endfunction

    // Drive one start at a negedge; returns at the following negedge (cycle 1).
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi, input logic [31:0] lo,
                                 input logic [63:0] expRes, input logic expDbz, input bit track);
        sb_item_t item;
        bus0.op_i    = op;
        bus0.src1_i  = a;
        bus0.src2_i  = b;
        bus0.hi_i    = hi;
        bus0.lo_i    = lo;
        bus0.annul_i = 1'b0;
        bus0.start_i = 1'b1;
        if (track) begin
            item.res       = expRes;
            item.dbz       = expDbz;
            item.startEdge = edgeCnt + 1;
            item.cyc       = (op[2:1] == 2'b01 && b == 32'h0) ? 1 : 33;
            sbQ.push_back(item);
            lastRes = expRes;
        end
        @(negedge clk);
        bus0.start_i = 1'b0;
        bus0.src1_i  = $urandom;
        bus0.src2_i  = $urandom;
        bus0.hi_i    = $urandom;
        bus0.lo_i    = $urandom;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 100 && sbQ.size() != 0; i++) @(negedge clk);
        if (sbQ.size() != 0) begin
            checkOutput("drain_timeout", 64'(sbQ.size()), 64'd0);
            sbQ.delete();
        end
    endtask

    // Monitor: pop and compare on every ready_o pulse.
    initial begin
        sb_item_t item;
        edgeCnt = 0;
        forever begin
            @(posedge clk);
            edgeCnt++;
            #1;
            if (resetn && bus0.ready_o) begin
                if (sbQ.size() == 0) begin
                    checkOutput("spurious_ready", 64'(bus0.ready_o), 64'd0);
                end else begin
                    item = sbQ.pop_front();
                    checkOutput("result", bus0.result_o, item.res);
                    checkOutput("dbz", 64'(bus0.div_by_zero_o), 64'(item.dbz));
                    checkOutput("latency", 64'(edgeCnt - item.startEdge + 1), 64'(item.cyc));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [64:0] m;
        logic [2:0]  rop;
        logic [31:0] ra, rb, rhi, rlo;
        int          gotCyc;
        total   = 0;
        bad     = 0;
        lastRes = 64'h0;
        resetn  = 1'b0;
        bus0.start_i = 1'b0; bus0.op_i = 3'd0; bus0.src1_i = '0; bus0.src2_i = '0;
        bus0.hi_i = '0; bus0.lo_i = '0; bus0.annul_i = 1'b0;
        bus1.start_i = 1'b0; bus1.op_i = 3'd0; bus1.src1_i = '0; bus1.src2_i = '0;
        bus1.hi_i = '0; bus1.lo_i = '0; bus1.annul_i = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 64'(bus0.busy_o), 64'd0);
        checkOutput("rst_ready", 64'(bus0.ready_o), 64'd0);
        checkOutput("rst_result", bus0.result_o, 64'd0);
        checkOutput("rst_dbz", 64'(bus0.div_by_zero_o), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 64'hFFFFFFFE_00000001, 1'b0, 1);
        checkOutput("mul_busy", 64'(bus0.busy_o), 64'd1);
        waitDrain();
        applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2, 0, 0, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 1);
        waitDrain();
        applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 64'h00000000_80000000, 1'b0, 1);
        waitDrain();
        applyStimulus(3'd3, 32'd5, 32'd0, 0, 0, 64'h00000005_FFFFFFFF, 1'b1, 1);
        checkOutput("dbz_busy", 64'(bus0.busy_o), 64'd0);
        waitDrain();
        applyStimulus(3'd6, 32'd3, 32'd4, 32'd0, 32'd10, 64'hFFFFFFFF_FFFFFFFE, 1'b0, 1);
        waitDrain();
        applyStimulus(3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 64'h00000001_00000000, 1'b0, 1);
        waitDrain();

        // Back-to-back starts while in DONE
        applyStimulus(3'd3, 32'd5, 32'd0, 0, 0, 64'h00000005_FFFFFFFF, 1'b1, 1);
        applyStimulus(3'd2, 32'd9, 32'd0, 0, 0, 64'h00000009_FFFFFFFF, 1'b1, 1);
        waitDrain();
        applyStimulus(3'd3, 32'd5, 32'd0, 0, 0, 64'h00000005_FFFFFFFF, 1'b1, 1);
        applyStimulus(3'd1, 32'd3, 32'd4, 0, 0, 64'h00000000_0000000C, 1'b0, 1);
        waitDrain();

        // Annul a divide in cycle 10
        applyStimulus(3'd2, 32'd100, 32'd7, 0, 0, 64'h0, 1'b0, 0);
        repeat (9) @(negedge clk);
        checkOutput("annul_busy_pre", 64'(bus0.busy_o), 64'd1);
        bus0.annul_i = 1'b1;
        @(negedge clk);
        bus0.annul_i = 1'b0;
        checkOutput("annul_busy_post", 64'(bus0.busy_o), 64'd0);
        checkOutput("annul_ready", 64'(bus0.ready_o), 64'd0);
        checkOutput("annul_result", bus0.result_o, lastRes);
        repeat (40) @(negedge clk);
        applyStimulus(3'd0, 32'hFFFFFFFE, 32'd3, 0, 0, 64'hFFFFFFFF_FFFFFFFA, 1'b0, 1);
        waitDrain();

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i == 3) ? 32'h0 : $urandom;
            rhi = $urandom;
            rlo = $urandom;
            m   = modelOp(rop, ra, rb, rhi, rlo);
            applyStimulus(rop, ra, rb, rhi, rlo, m[63:0], m[64], 1);
            waitDrain();
        end

        // Reset in the middle of a MULT, with start held through reset
        applyStimulus(3'd0, 32'd7, 32'd9, 0, 0, 64'h0, 1'b0, 0);
        repeat (4) @(negedge clk);
        resetn       = 1'b0;
        bus0.op_i    = 3'd0;
        bus0.start_i = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", 64'(bus0.busy_o), 64'd0);
        checkOutput("midrst_ready", 64'(bus0.ready_o), 64'd0);
        checkOutput("midrst_result", bus0.result_o, 64'd0);
        checkOutput("midrst_dbz", 64'(bus0.div_by_zero_o), 64'd0);
        repeat (2) @(negedge clk);
        checkOutput("midrst_start_ignored", 64'(bus0.busy_o), 64'd0);
        bus0.start_i = 1'b0;
        resetn       = 1'b1;
        @(negedge clk);
        checkOutput("postrst_busy", 64'(bus0.busy_o), 64'd0);
        lastRes = 64'h0;

        // Four bits per cycle on the second instance
        bus1.op_i    = 3'd1;
        bus1.src1_i  = 32'hFFFFFFFF;
        bus1.src2_i  = 32'hFFFFFFFF;
        bus1.start_i = 1'b1;
        gotCyc = 0;
        for (int c = 1; c <= 20 && gotCyc == 0; c++) begin
            @(posedge clk);
            #1;
            bus1.start_i = 1'b0;
            if (bus1.ready_o) gotCyc = c;
        end
        checkOutput("bpc4_latency", 64'(gotCyc), 64'd9);
        checkOutput("bpc4_result", bus1.result_o, 64'hFFFFFFFE_00000001);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
